// File: rtl/fifo_wr_ctrl_if.sv
// Handshake and occupancy bundle between the producer/read side and the FIFO write controller.
// The master modport drives the producer handshake and pop strobe; the slave modport is the controller.
interface fifo_wr_ctrl_if #(
  parameter int ADDR_W = 3
);
  logic              write_en;
  logic              rd_ack;
  logic              ld_w;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic              ready;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;

  modport master (
    output write_en, rd_ack,
    input  ld_w, waddr, raddr, ready, empty, full, count
  );

  modport slave (
    input  write_en, rd_ack,
    output ld_w, waddr, raddr, ready, empty, full, count
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// FIFO write-side controller: four-phase producer handshake, write strobe generation,
// and read/write pointer tracking with empty/full/count decoded from the pointers.
module fifo_wr_ctrl #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  fifo_wr_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WRITE = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic            ld_w_q, ld_w_d;
  logic            ready_q, ready_d;
  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] rptr_q, rptr_d;

  logic empty_w;
  logic full_w;

  // Flags come from registered pointers only, so no input reaches them combinationally.
  assign empty_w = (wptr_q == rptr_q);
  assign full_w  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                   (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);

  // Outputs are registered alongside the state so they are a pure function of it.
  always_comb begin
    state_d = S_IDLE;
    ld_w_d  = 1'b0;
    ready_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.write_en && !full_w) begin
          state_d = S_WRITE;
          ld_w_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        state_d = S_DONE;
        ready_d = 1'b1;
      end
      S_DONE: begin
        if (bus.write_en) begin
          state_d = S_DONE;
          ready_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The write strobe cycle retires one word; a pop against an empty FIFO is dropped.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (ld_w_q) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (bus.rd_ack && !empty_w) begin
      rptr_d = rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ld_w_q  <= 1'b0;
      ready_q <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      ld_w_q  <= ld_w_d;
      ready_q <= ready_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  assign bus.ld_w  = ld_w_q;
  assign bus.ready = ready_q;
  assign bus.waddr = wptr_q[ADDR_W-1:0];
  assign bus.raddr = rptr_q[ADDR_W-1:0];
  assign bus.empty = empty_w;
  assign bus.full  = full_w;
  assign bus.count = wptr_q - rptr_q;

endmodule
